// File: rtl/priority_scan_stream.sv
// priority_scan_stream
//   Accepts one WIDTH-bit word per valid/ready handshake and emits every set
//   bit of it as a separate one-hot beat, one beat per cycle, together with
//   its binary index. The scan order (LSB-first or MSB-first) is chosen per
//   word by dir_i. An all-zero word produces a single beat flagged empty_o.
//
// Handshake rule (both sides): a transfer happens on a posedge of clk_i when
//   valid and ready are both high. A valid source holds its payload stable
//   until that transfer. ready may depend combinationally on the other side's
//   ready (data_ready_o follows data_ready_i on the final beat) but never on
//   valid.
//
// Ports
//   clk_i         clock, all logic on posedge
//   srst_n_i      synchronous reset, active-low
//   data_i        word to scan
//   dir_i         scan order for this word: 0 = LSB-first, 1 = MSB-first
//   data_val_i    input word valid
//   data_ready_o  block can accept a word
//   onehot_o      current beat (zero for an empty word)
//   idx_o         binary index of the bit in onehot_o (0 for an empty word)
//   empty_o       current beat represents an all-zero input word
//   last_o        current beat is the final beat of its word
//   data_val_o    output beat valid
//   data_ready_i  downstream accepts beat
//   dbg_state_o   FSM state for observation: 0 = IDLE, 1 = SCAN

module priority_scan_stream #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             dir_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o,
    output logic             last_o,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic             dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] onehot_q, onehot_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             empty_q, empty_d;
    logic             last_q, last_d;

    logic             accept;
    logic             out_hs;
    logic [WIDTH-1:0] src;
    logic             src_dir;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] src_left;

    // Lowest set bit via two's complement isolation.
    function automatic logic [WIDTH-1:0] pick_lsb(input logic [WIDTH-1:0] v);
        return v & (~v + WIDTH'(1));
    endfunction

    // Highest set bit: the last set bit seen on an ascending walk wins.
    function automatic logic [WIDTH-1:0] pick_msb(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One-hot to binary; yields 0 for a zero vector.
    function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                r = r | IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Ready while idle, or on the cycle the final beat of the current word is
    // taken, so a new word can follow with no bubble.
    assign data_ready_o = srst_n_i &
                          ((state_q == ST_IDLE) | (data_val_o & last_q & data_ready_i));
    assign data_val_o   = (state_q == ST_SCAN);
    assign accept       = data_val_i & data_ready_o;
    assign out_hs       = data_val_o & data_ready_i;

    assign onehot_o     = onehot_q;
    assign idx_o        = idx_q;
    assign empty_o      = empty_q;
    assign last_o       = last_q;
    assign dbg_state_o  = state_q;

    // A freshly accepted word is scanned directly from data_i; otherwise the
    // next beat comes from the remaining-bits register.
    always_comb begin
        src      = accept ? data_i : rem_q;
        src_dir  = accept ? dir_i : dir_q;
        sel      = src_dir ? pick_msb(src) : pick_lsb(src);
        src_left = src & ~sel;
    end

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
        empty_d  = empty_q;
        last_d   = last_q;

        if (accept) begin
            state_d  = ST_SCAN;
            dir_d    = dir_i;
            rem_d    = src_left;
            onehot_d = sel;
            idx_d    = encode(sel);
            empty_d  = (data_i == '0);
            last_d   = (src_left == '0);
        end else if (out_hs) begin
            if (!last_q) begin
                state_d  = ST_SCAN;
                rem_d    = src_left;
                onehot_d = sel;
                idx_d    = encode(sel);
                empty_d  = 1'b0;
                last_d   = (src_left == '0);
            end else begin
                state_d  = ST_IDLE;
                rem_d    = '0;
                onehot_d = '0;
                idx_d    = '0;
                empty_d  = 1'b0;
                last_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            onehot_q <= '0;
            idx_q    <= '0;
            empty_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            dir_q    <= dir_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
            empty_q  <= empty_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_stream.sv
// tb_priority_scan_stream
//   Self-checking bench for priority_scan_stream. Inputs are driven on the
//   falling edge, outputs are sampled 1 time unit later. Expected beats come
//   from a bit-walking reference model and are queued in exp_q when a word is
//   offered; each beat that handshakes pops and compares the queue head.

module tb_priority_scan_stream;

    localparam int WIDTH = 16;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int EW    = WIDTH + IDX_W + 2;

    logic             clk_i = 1'b0;
    logic             srst_n_i;
    logic [WIDTH-1:0] data_i;
    logic             dir_i;
    logic             data_val_i;
    logic             data_ready_o;
    logic [WIDTH-1:0] onehot_o;
    logic [IDX_W-1:0] idx_o;
    logic             empty_o;
    logic             last_o;
    logic             data_val_o;
    logic             data_ready_i;
    logic             dbg_state_o;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs;
    logic [EW-1:0] exp_v;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk_i = ~clk_i;

    priority_scan_stream #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .srst_n_i     (srst_n_i),
        .data_i       (data_i),
        .dir_i        (dir_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .onehot_o     (onehot_o),
        .idx_o        (idx_o),
        .empty_o      (empty_o),
        .last_o       (last_o),
        .data_val_o   (data_val_o),
        .data_ready_i (data_ready_i),
        .dbg_state_o  (dbg_state_o)
    );

    assign obs = {onehot_o, idx_o, empty_o, last_o};

    // Reference model: walk bit positions in scan order, one beat per set bit.
    task automatic model_push(input logic [WIDTH-1:0] w, input logic d);
        int               total;
        int               n;
        int               pos;
        logic [WIDTH-1:0] oh;
        total = $countones(w);
        n     = 0;
        if (total == 0) begin
            exp_q.push_back({{WIDTH{1'b0}}, {IDX_W{1'b0}}, 1'b1, 1'b1});
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                pos = d ? (WIDTH - 1 - k) : k;
                if (w[pos]) begin
                    n       = n + 1;
                    oh      = '0;
                    oh[pos] = 1'b1;
                    exp_q.push_back({oh, IDX_W'(pos), 1'b0, (n == total)});
                end
            end
        end
    endtask

    // Offer a word on the next falling edge and queue its expected beats.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic d);
        @(negedge clk_i);
        data_i     = w;
        dir_i      = d;
        data_val_i = 1'b1;
        model_push(w, d);
        #1;
    endtask

    task automatic test_reset;
        srst_n_i     = 1'b0;
        data_val_i   = 1'b0;
        data_i       = '0;
        dir_i        = 1'b0;
        data_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        n_checks++;
        if (data_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b expected 0", data_ready_o);
        end
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_val: got %b expected 0", data_val_o);
        end
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        @(negedge clk_i);
        srst_n_i = 1'b1;
        #1;
        n_checks++;
        if (data_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", data_ready_o);
        end
    endtask

    task automatic test_lsb;
        data_ready_i = 1'b1;
        send_word(16'h8421, 1'b0);
        n_checks++;
        if (data_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_accept: ready got %b expected 1", data_ready_o);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            data_i     = WIDTH'($urandom);
            dir_i      = 1'b1;
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL lsb_beat%0d: got %h val %b expected %h val 1", c, obs, data_val_o, exp_v);
            end
            n_checks++;
            if (data_ready_o !== (c == 3)) begin
                n_fail++;
                $display("FAIL lsb_ready%0d: got %b expected %b", c, data_ready_o, (c == 3));
            end
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_idle: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_msb_backpressure;
        data_ready_i = 1'b0;
        send_word(16'h0003, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q[0] : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL msb_hold%0d: got %h val %b expected %h val 1", c, obs, data_val_o, exp_v);
            end
            n_checks++;
            if (data_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL msb_hold_ready%0d: got %b expected 0", c, data_ready_o);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            data_ready_i = 1'b1;
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL msb_beat%0d: got %h val %b expected %h val 1", c, obs, data_val_o, exp_v);
            end
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL msb_idle: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_zero_word;
        data_ready_i = 1'b1;
        send_word('0, 1'b0);
        @(negedge clk_i);
        data_val_i = 1'b0;
        #1;
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if (data_val_o !== 1'b1 || obs !== exp_v) begin
            n_fail++;
            $display("FAIL zero_beat: got %h val %b expected %h val 1", obs, data_val_o, exp_v);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_back_to_back;
        data_ready_i = 1'b1;
        send_word(16'h0001, 1'b0);
        for (int c = 0; c < 17; c++) begin
            @(negedge clk_i);
            data_i     = 16'hFFFF;
            dir_i      = 1'b0;
            data_val_i = (c < 16);
            if (c == 0) model_push(16'hFFFF, 1'b0);
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got %h val %b expected %h val 1", c, obs, data_val_o, exp_v);
            end
            n_checks++;
            if (data_ready_o !== (c == 0 || c == 16)) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b expected %b", c, data_ready_o, (c == 0 || c == 16));
            end
        end
        @(negedge clk_i);
        data_val_i = 1'b0;
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_reset_mid_word;
        data_ready_i = 1'b1;
        send_word(16'hFFFF, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            data_val_i = 1'b0;
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_beat%0d: got %h val %b expected %h val 1", c, obs, data_val_o, exp_v);
            end
        end
        @(negedge clk_i);
        srst_n_i = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (data_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ready_low: got %b expected 0", data_ready_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0 || obs !== '0) begin
            n_fail++;
            $display("FAIL rstmid_flush: got %h val %b expected 0 val 0", obs, data_val_o);
        end
        @(negedge clk_i);
        srst_n_i = 1'b1;
        #1;
        n_checks++;
        if (data_ready_o !== 1'b1 || data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: ready %b val %b expected ready 1 val 0", data_ready_o, data_val_o);
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_beats: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_boundary;
        data_ready_i = 1'b1;
        for (int d = 0; d < 2; d++) begin
            send_word(16'h8000, d[0]);
            n_checks++;
            if (data_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL bound_accept_dir%0d: ready got %b expected 1", d, data_ready_o);
            end
            @(negedge clk_i);
            data_val_i = 1'b0;
            #1;
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++;
            if (data_val_o !== 1'b1 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL bound_beat_dir%0d: got %h val %b expected %h val 1", d, obs, data_val_o, exp_v);
            end
        end
        @(negedge clk_i);
        #1;
        n_checks++;
        if (data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bound_idle: val got %b expected 0", data_val_o);
        end
    endtask

    task automatic test_random;
        int n_words;
        int sent;
        int sel;
        n_words = 30;
        sent    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk_i);
            if (sent < n_words && $urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 5);
                if (sel == 0)      data_i = '0;
                else if (sel == 1) data_i = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                else               data_i = WIDTH'($urandom);
                dir_i      = 1'($urandom_range(0, 1));
                data_val_i = 1'b1;
            end else begin
                data_val_i = 1'b0;
            end
            data_ready_i = ($urandom_range(0, 3) != 0);
            #1;
            // The beat on the outputs predates any word accepted this cycle.
            if (data_val_o && data_ready_i) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_checks++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rand_beat cyc%0d: got %h expected %h", cyc, obs, exp_v);
                end
            end
            if (data_val_i && data_ready_o) begin
                model_push(data_i, dir_i);
                sent++;
            end
            if (sent == n_words && exp_q.size() == 0) break;
        end
        @(negedge clk_i);
        data_val_i = 1'b0;
        #1;
        n_checks++;
        if (sent != n_words || exp_q.size() != 0 || data_val_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: sent %0d of %0d, %0d beats outstanding, val %b expected 0",
                     sent, n_words, exp_q.size(), data_val_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lsb();
        test_msb_backpressure();
        test_zero_word();
        test_back_to_back();
        test_reset_mid_word();
        test_boundary();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
